// File: rtl/comp_nbit_serial.sv
// Bit-serial magnitude comparator.
// A comparison is accepted on start while idle. The latched operands are then
// walked MSB first, one bit pair per cycle. The first differing bit decides
// the result and ends the run early. If no bit differs, the run ends at the
// LSB with eq set. In two's-complement mode a difference in the sign bit
// inverts the ordering. All outputs come straight from registers.
module comp_nbit_serial #(
  parameter  int WIDTH = 8,
  localparam int IW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq,
  output logic [IW-1:0]    diff_pos
);

  localparam logic [IW-1:0] IDX_MSB  = IW'(WIDTH - 1);
  localparam logic [IW-1:0] IDX_ZERO = '0;
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Ordering of a single differing bit pair, returned as {gt, lt}.
  // For the sign bit of a two's-complement operand a set bit means a more
  // negative value, so the ordering flips.
  function automatic logic [1:0] bit_order(input logic bit_a,
                                           input logic bit_b,
                                           input logic is_sign);
    logic [1:0] order;
    if (is_sign) order = {bit_b, bit_a};
    else         order = {bit_a, bit_b};
    return order;
  endfunction

  // Registered state: FSM, latched operands, bit cursor and outputs.
  state_t           state_q;
  logic [WIDTH-1:0] opa_p0;
  logic [WIDTH-1:0] opb_p0;
  logic             sgn_p0;
  logic [IW-1:0]    idx_q;

  // Next-state values.
  state_t           state_d;
  logic [WIDTH-1:0] opa_d;
  logic [WIDTH-1:0] opb_d;
  logic             sgn_d;
  logic [IW-1:0]    idx_d;
  logic             busy_d;
  logic             done_d;
  logic             gt_d;
  logic             lt_d;
  logic             eq_d;
  logic [IW-1:0]    diff_pos_d;

  // Bit pair under examination and its ordering.
  logic             bit_a;
  logic             bit_b;
  logic [1:0]       order;

  assign bit_a = opa_p0[idx_q];
  assign bit_b = opb_p0[idx_q];
  assign order = bit_order(bit_a, bit_b, sgn_p0 && (idx_q == IDX_MSB));

  // Next-state and next-output logic. Everything holds by default. done is
  // the exception: it defaults low, which makes it a single-cycle pulse.
  always_comb begin
    state_d    = state_q;
    opa_d      = opa_p0;
    opb_d      = opb_p0;
    sgn_d      = sgn_p0;
    idx_d      = idx_q;
    busy_d     = busy;
    done_d     = 1'b0;
    gt_d       = gt;
    lt_d       = lt;
    eq_d       = eq;
    diff_pos_d = diff_pos;

    case (state_q)
      IDLE: begin
        if (start) begin
          opa_d      = a;
          opb_d      = b;
          sgn_d      = signed_mode;
          idx_d      = IDX_MSB;
          gt_d       = 1'b0;
          lt_d       = 1'b0;
          eq_d       = 1'b0;
          diff_pos_d = IDX_ZERO;
          busy_d     = 1'b1;
          state_d    = RUN;
        end
      end

      RUN: begin
        if (bit_a != bit_b) begin
          // First difference from the top settles the comparison.
          {gt_d, lt_d} = order;
          eq_d         = 1'b0;
          diff_pos_d   = idx_q;
          done_d       = 1'b1;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end else if (idx_q != IDX_ZERO) begin
          idx_d = idx_q - IDX_ONE;
        end else begin
          // Walked past the LSB without a difference.
          gt_d       = 1'b0;
          lt_d       = 1'b0;
          eq_d       = 1'b1;
          diff_pos_d = IDX_ZERO;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset overrides any accept or RUN update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      opa_p0   <= '0;
      opb_p0   <= '0;
      sgn_p0   <= 1'b0;
      idx_q    <= IDX_MSB;
      busy     <= 1'b0;
      done     <= 1'b0;
      gt       <= 1'b0;
      lt       <= 1'b0;
      eq       <= 1'b0;
      diff_pos <= IDX_ZERO;
    end else begin
      state_q  <= state_d;
      opa_p0   <= opa_d;
      opb_p0   <= opb_d;
      sgn_p0   <= sgn_d;
      idx_q    <= idx_d;
      busy     <= busy_d;
      done     <= done_d;
      gt       <= gt_d;
      lt       <= lt_d;
      eq       <= eq_d;
      diff_pos <= diff_pos_d;
    end
  end

endmodule

// File: tb/tb_comp_nbit_serial.sv
// Directed and randomized checks of the bit-serial comparator at WIDTH=8.
module tb_comp_nbit_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       signed_mode;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic       gt;
  logic       lt;
  logic       eq;
  logic [2:0] diff_pos;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  comp_nbit_serial #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_mode(signed_mode),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .gt         (gt),
    .lt         (lt),
    .eq         (eq),
    .diff_pos   (diff_pos)
  );

  // Drives one start pulse. Returns 1 ns after the accepting edge, with start still high.
  task automatic launch(input logic [7:0] ia, input logic [7:0] ib, input logic ism);
    @(negedge clk);
    a = ia; b = ib; signed_mode = ism; start = 1'b1;
    @(posedge clk); #1;
  endtask

  // Drops start and waits for done. lat=0 means done never arrived.
  task automatic wait_done(output int lat, output int busy_cyc);
    lat = 0;
    busy_cyc = busy ? 1 : 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk); start = 1'b0;
      @(posedge clk); #1;
      if (busy) busy_cyc++;
      if (done) begin lat = n; break; end
    end
  endtask

  // Reference result built from whole-word arithmetic.
  function automatic void ref_cmp(input logic [7:0] x, input logic [7:0] y, input logic sm,
                                  output logic [2:0] gle, output logic [2:0] dp,
                                  output int lat);
    logic signed [8:0] sx, sy;
    sx = sm ? $signed({x[7], x}) : $signed({1'b0, x});
    sy = sm ? $signed({y[7], y}) : $signed({1'b0, y});
    if (sx > sy)      gle = 3'b100;
    else if (sx < sy) gle = 3'b010;
    else              gle = 3'b001;
    dp = 3'd0;
    for (int i = 0; i < 8; i++) if (x[i] != y[i]) dp = i[2:0];
    lat = (x == y) ? 8 : 8 - int'(dp);
  endfunction

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = 8'h00; b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, gt, lt, eq, diff_pos} !== 8'h00) begin
      errors++; $display("FAIL reset_state got %b want 00000000", {busy, done, gt, lt, eq, diff_pos});
    end
    // Reset wins over a simultaneous start.
    @(negedge clk); start = 1'b1; a = 8'hA5; b = 8'h5A;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_priority busy got %b want 0", busy); end
    @(negedge clk); start = 1'b0; rst = 1'b0;
  endtask

  task automatic test_msb_differs;
    int lat, bc;
    launch(8'hA5, 8'h5A, 1'b0);
    checks++;
    if ({busy, done} !== 2'b10) begin errors++; $display("FAIL msb_accept busy,done got %b want 10", {busy, done}); end
    wait_done(lat, bc);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL msb_latency got %0d want 1", lat); end
    checks++;
    if ({gt, lt, eq} !== 3'b100) begin errors++; $display("FAIL msb_gle got %b want 100", {gt, lt, eq}); end
    checks++;
    if (diff_pos !== 3'd7) begin errors++; $display("FAIL msb_diffpos got %0d want 7", diff_pos); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL msb_busy_clear got %b want 0", busy); end
    @(posedge clk); #1;
    checks++;
    if ({done, gt, lt, eq, diff_pos} !== 7'b0100111) begin
      errors++; $display("FAIL msb_hold done,gle,pos got %b want 0100111", {done, gt, lt, eq, diff_pos});
    end
  endtask

  task automatic test_lsb_differs;
    int lat, bc;
    launch(8'h12, 8'h13, 1'b0);
    wait_done(lat, bc);
    checks++;
    if (lat != 8) begin errors++; $display("FAIL lsb_latency got %0d want 8", lat); end
    checks++;
    if (bc != 8) begin errors++; $display("FAIL lsb_busy_cycles got %0d want 8", bc); end
    checks++;
    if ({gt, lt, eq, diff_pos} !== 6'b010000) begin
      errors++; $display("FAIL lsb_result gle,pos got %b want 010000", {gt, lt, eq, diff_pos});
    end
  endtask

  task automatic test_equal;
    int lat, bc;
    for (int m = 0; m < 2; m++) begin
      launch(8'h3C, 8'h3C, m[0]);
      wait_done(lat, bc);
      checks++;
      if (lat != 8) begin errors++; $display("FAIL equal_latency mode %0d got %0d want 8", m, lat); end
      checks++;
      if ({gt, lt, eq, diff_pos} !== 6'b001000) begin
        errors++; $display("FAIL equal_result mode %0d got %b want 001000", m, {gt, lt, eq, diff_pos});
      end
    end
  endtask

  task automatic test_signed;
    int lat, bc;
    launch(8'h80, 8'h01, 1'b1);
    wait_done(lat, bc);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL signed_latency got %0d want 1", lat); end
    checks++;
    if ({gt, lt, eq, diff_pos} !== 6'b010111) begin
      errors++; $display("FAIL signed_result got %b want 010111", {gt, lt, eq, diff_pos});
    end
    launch(8'h80, 8'h01, 1'b0);
    wait_done(lat, bc);
    checks++;
    if ({gt, lt, eq, diff_pos} !== 6'b100111 || lat != 1) begin
      errors++; $display("FAIL unsigned_sign_bit got %b lat %0d want 100111 lat 1", {gt, lt, eq, diff_pos}, lat);
    end
  endtask

  task automatic test_busy_ignore;
    int lat;
    lat = 0;
    launch(8'h01, 8'h00, 1'b0);          // accepted at edge 0
    @(negedge clk); start = 1'b0;
    @(posedge clk);                      // edge 1
    @(posedge clk);                      // edge 2
    @(negedge clk); start = 1'b1; a = 8'h00; b = 8'hFF; signed_mode = 1'b1;
    @(posedge clk); #1;                  // edge 3
    checks++;
    if ({busy, done} !== 2'b10) begin errors++; $display("FAIL ignore_restart busy,done got %b want 10", {busy, done}); end
    @(negedge clk); start = 1'b0;
    for (int n = 4; n <= 12; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
    checks++;
    if (lat != 8) begin errors++; $display("FAIL ignore_latency got %0d want 8", lat); end
    checks++;
    if ({gt, lt, eq, diff_pos} !== 6'b100000) begin
      errors++; $display("FAIL ignore_result got %b want 100000", {gt, lt, eq, diff_pos});
    end
  endtask

  task automatic test_reset_mid_run;
    logic saw_done;
    saw_done = 1'b0;
    launch(8'h12, 8'h13, 1'b0);          // edge 0
    @(negedge clk); start = 1'b0;
    repeat (3) @(posedge clk);           // edges 1..3
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;                  // edge 4: reset
    checks++;
    if ({busy, done, gt, lt, eq, diff_pos} !== 8'h00) begin
      errors++; $display("FAIL midrun_reset got %b want 00000000", {busy, done, gt, lt, eq, diff_pos});
    end
    @(negedge clk); rst = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL midrun_no_done got activity %b want 0", saw_done); end
  endtask

  task automatic test_back_to_back;
    launch(8'hA5, 8'h5A, 1'b0);          // edge 0, start held high
    @(negedge clk); a = 8'h80; b = 8'h01; signed_mode = 1'b1;
    @(posedge clk); #1;                  // edge 1: first result
    checks++;
    if ({done, gt, lt, eq} !== 4'b1100) begin
      errors++; $display("FAIL b2b_first got done,gle %b want 1100", {done, gt, lt, eq});
    end
    @(posedge clk); #1;                  // edge 2: start accepted in the done cycle
    checks++;
    if ({busy, done, gt, lt, eq} !== 5'b10000) begin
      errors++; $display("FAIL b2b_accept got busy,done,gle %b want 10000", {busy, done, gt, lt, eq});
    end
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;                  // edge 3: second result
    checks++;
    if ({done, gt, lt, eq, diff_pos} !== 7'b1010111) begin
      errors++; $display("FAIL b2b_second got %b want 1010111", {done, gt, lt, eq, diff_pos});
    end
  endtask

  task automatic test_random;
    int lat, bc, exp_lat;
    logic [7:0] ra, rb;
    logic [2:0] exp_gle, exp_dp;
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (i % 6 == 5) ? ra : 8'($urandom_range(0, 255));
      ref_cmp(ra, rb, i[0], exp_gle, exp_dp, exp_lat);
      launch(ra, rb, i[0]);
      wait_done(lat, bc);
      checks++;
      if ({gt, lt, eq} !== exp_gle || diff_pos !== exp_dp || lat != exp_lat) begin
        errors++;
        $display("FAIL random a=%h b=%h sm=%0d got gle %b pos %0d lat %0d want gle %b pos %0d lat %0d",
                 ra, rb, i[0], {gt, lt, eq}, diff_pos, lat, exp_gle, exp_dp, exp_lat);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = 8'h00; b = 8'h00;
    test_reset();
    test_msb_differs();
    test_lsb_differs();
    test_equal();
    test_signed();
    test_busy_ignore();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
